// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start=1, DATA_W data bits, optional even parity, stop=0; one-word output buffer.
// Parity bit and parity_err port exist only when SERIAL_FRAME_RX_PARITY_EN is defined.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef SERIAL_FRAME_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_next;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic                par;
`endif

  // Shift direction decides which dout bit the first received data bit lands in.
  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST)
      shreg_next = (shreg << 1) | DATA_W'(sin);
    else
      shreg_next = (shreg >> 1) | (DATA_W'(sin) << (DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (sin) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
              par   <= 1'b0;
`endif
            end
          end
          DATA: begin
            shreg <= shreg_next;
            cnt   <= cnt + CW'(1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par   <= par ^ sin;
            if (cnt == LAST)
              state <= PARITY;
`else
            if (cnt == LAST)
              state <= STOP;
`endif
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          PARITY: begin
            par   <= par ^ sin;
            state <= STOP;
          end
`endif
          STOP: begin
            // A 1 here is a broken stop bit, never a fresh start bit.
            state <= IDLE;
            busy  <= 1'b0;
            if (sin)
              frame_err <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            else if (par)
              parity_err <= 1'b1;
`endif
            else if (!dout_valid || dout_ready) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
            end else
              overrun <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus queues expected words/pulses, a negedge monitor consumes them.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin;
  logic       bit_en;
  logic       dout_ready;
  logic       one;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overrun, busy;
  logic [7:0] dout_l;
  logic       valid_l, fe_l, ov_l, busy_l;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic       parity_err, pe_l;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_data[$];
  int         exp_evt[$];

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
`ifdef SERIAL_FRAME_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  serial_frame_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(one),
    .frame_err(fe_l), .overrun(ov_l), .busy(busy_l)
`ifdef SERIAL_FRAME_RX_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_evt(input int kind);
    if (exp_evt.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else
      chk("pulse_kind", 32'(kind), 32'(exp_evt.pop_front()));
  endtask

  // Monitor: words counted on handshake, status pulses counted when seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", dout);
        end else
          chk("word", 32'(dout), 32'(exp_data.pop_front()));
      end
      if (frame_err) check_evt(1);
      if (overrun)   check_evt(2);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      if (parity_err) check_evt(3);
`endif
    end
  end

  task automatic drive(input logic b, input logic en);
    sin    = b;
    bit_en = en;
    @(posedge clk);
    #1;
  endtask

  // MSB of d goes on the line first; stretch inserts bit_en=0 cycles carrying the inverted bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic stretch);
    drive(1'b1, 1'b1);
    if (stretch) drive(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive(d[i], 1'b1);
      if (stretch) drive(~d[i], 1'b0);
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    drive(^d, 1'b1);
`endif
    drive(stop_bit, 1'b1);
  endtask

  initial begin
    sin        = 1'b0;
    bit_en     = 1'b0;
    dout_ready = 1'b1;
    one        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    drive(1'b0, 1'b1);

    // Basic frame; valid must already be high right after the stop-bit edge.
    exp_data.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_valid_at_stop", 32'(dout_valid), 1);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_lsb_dout", 32'(dout_l), 32'hA5);

    // Back-to-back frames with no idle bits.
    exp_data.push_back(8'h12);
    exp_data.push_back(8'h34);
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0);
    chk("b2b_dout", 32'(dout), 32'h34);

    // Bad stop bit, then an immediate good frame.
    exp_evt.push_back(1);
    send_frame(8'h55, 1'b1, 1'b0);
    chk("fe_busy", 32'(busy), 0);
    chk("fe_valid", 32'(dout_valid), 0);
    exp_data.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("after_fe_dout", 32'(dout), 32'h81);
    drive(1'b0, 1'b1);

    // Overrun with consumer stalled.
    dout_ready = 1'b0;
    exp_data.push_back(8'h3C);
    exp_evt.push_back(2);
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("ovr_dout_held", 32'(dout), 32'h3C);
    chk("ovr_valid", 32'(dout_valid), 1);
    dout_ready = 1'b1;
    drive(1'b0, 1'b1);
    chk("ovr_drained", 32'(dout_valid), 0);

    // Reset in the middle of a frame, then a stretched frame.
    drive(1'b1, 1'b1);
    repeat (4) drive(1'b1, 1'b1);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    exp_data.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("stretch_dout", 32'(dout), 32'h0F);
    chk("stretch_lsb_dout", 32'(dout_l), 32'hF0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    exp_evt.push_back(3);
    drive(1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) drive(i == 0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("par_bad_valid", 32'(dout_valid), 0);
    exp_data.push_back(8'h01);
    send_frame(8'h01, 1'b0, 1'b0);
    chk("par_good_dout", 32'(dout), 32'h01);
`endif

    repeat (4) drive(1'b0, 1'b1);
    chk("words_left", 32'(exp_data.size()), 0);
    chk("pulses_left", 32'(exp_evt.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
